axi_rd_responder: RTL

- AXI4 slave read-channel responder: accepts AR requests and returns R bursts with a deterministic address-derived data pattern.
- It is the bench-side DUT endpoint for the read master driver, sized from the shared params package (ID 5, ADDR 32, DATA 8, LEN 8).
- It provides a checkable read target: every returned byte is a function of its byte address.

---
 rtl/axi_rd_responder.sv | 194 +++++++++++++++++++
 1 files changed

// File: rtl/axi_rd_responder.sv
// axi_rd_responder: AXI4 slave read-channel responder.
// Accepts AR requests and returns R bursts. Each returned byte is derived from
// its byte address: (addr & 8'hFF) ^ PATTERN_SEED. Beats outside MEM_BYTES and
// illegal request shapes are answered with SLVERR and zero data.
// Optional build macro AXI_RD_AR_PIPE_EN: one-entry AR holding register so a
// queued request starts right after the current burst's last beat.
module axi_rd_responder #(
  parameter int         C_AXI_ID_WIDTH   = 5,
  parameter int         C_AXI_ADDR_WIDTH = 32,
  parameter int         C_AXI_DATA_WIDTH = 8,
  parameter int         C_AXI_LEN_WIDTH  = 8,
  parameter int         MEM_BYTES        = 4096,
  parameter logic [7:0] PATTERN_SEED     = 8'hA5
) (
  input  logic                        S_AXI_ACLK,
  input  logic                        S_AXI_ARESETN,
  input  logic [C_AXI_ID_WIDTH-1:0]   S_AXI_ARID,
  input  logic [C_AXI_ADDR_WIDTH-1:0] S_AXI_ARADDR,
  input  logic [C_AXI_LEN_WIDTH-1:0]  S_AXI_ARLEN,
  input  logic [2:0]                  S_AXI_ARSIZE,
  input  logic [1:0]                  S_AXI_ARBURST,
  input  logic                        S_AXI_ARVALID,
  output logic                        S_AXI_ARREADY,
  output logic [C_AXI_ID_WIDTH-1:0]   S_AXI_RID,
  output logic [C_AXI_DATA_WIDTH-1:0] S_AXI_RDATA,
  output logic [1:0]                  S_AXI_RRESP,
  output logic                        S_AXI_RLAST,
  output logic                        S_AXI_RVALID,
  input  logic                        S_AXI_RREADY
);
  localparam int BUS_BYTES = C_AXI_DATA_WIDTH / 8;
  localparam int BUS_LOG2  = $clog2(BUS_BYTES);
  localparam int AW = C_AXI_ADDR_WIDTH;
  localparam int LW = C_AXI_LEN_WIDTH;
  localparam int IW = C_AXI_ID_WIDTH;

  localparam logic [0:0] ST_IDLE  = 1'b0;
  localparam logic [0:0] ST_BURST = 1'b1;

  logic [0:0]    state, state_nxt;
  logic          arready, arready_nxt;
  logic [IW-1:0] id_q;
  logic [AW-1:0] addr_q;
  logic [LW-1:0] len_q, cnt_q;
  logic [2:0]    size_q;
  logic [1:0]    burst_q;

  logic          load;
  logic [IW-1:0] src_id;
  logic [AW-1:0] src_addr;
  logic [LW-1:0] src_len;
  logic [2:0]    src_size;
  logic [1:0]    src_burst;

  logic          ar_hs, r_hs, last, last_hs;
  logic          size_bad, wrap_ok, err_all, out_range, slverr;
  logic [2:0]    eff_size;
  logic [AW-1:0] step, wrap_mask, beat_addr, next_addr, lane_addr;
  logic [C_AXI_DATA_WIDTH-1:0] rdata_c;

  assign ar_hs   = S_AXI_ARVALID && arready;
  assign r_hs    = (state == ST_BURST) && S_AXI_RREADY;
  assign last    = (cnt_q == len_q);
  assign last_hs = r_hs && last;

  // Decode the latched request: beat size, error class and next beat address
  always_comb begin
    size_bad  = (size_q > 3'(BUS_LOG2));
    eff_size  = size_bad ? 3'(BUS_LOG2) : size_q;
    step      = AW'(1) << eff_size;
    wrap_ok   = (len_q == LW'(1)) || (len_q == LW'(3)) ||
                (len_q == LW'(7)) || (len_q == LW'(15));
    wrap_mask = ((AW'(len_q) + AW'(1)) << eff_size) - AW'(1);
    beat_addr = addr_q & ~(step - AW'(1));
    err_all   = size_bad || (burst_q == 2'b11) || ((burst_q == 2'b10) && !wrap_ok);
    out_range = (beat_addr >= AW'(MEM_BYTES));
    slverr    = err_all || out_range;
    case (burst_q)
      2'b01:   next_addr = addr_q + step;
      2'b10:   next_addr = wrap_ok ? ((addr_q & ~wrap_mask) | ((addr_q + step) & wrap_mask))
                                   : (addr_q + step);
      default: next_addr = addr_q;
    endcase
  end

  // Fill the byte lanes covered by the current beat from their byte addresses
  always_comb begin
    rdata_c   = '0;
    lane_addr = '0;
    for (int k = 0; k < BUS_BYTES; k++) begin
      lane_addr = (beat_addr & ~AW'(BUS_BYTES - 1)) + AW'(k);
      if ((lane_addr & ~(step - AW'(1))) == beat_addr)
        rdata_c[8*k +: 8] = lane_addr[7:0] ^ PATTERN_SEED;
    end
    if ((state != ST_BURST) || slverr) rdata_c = '0;
  end

`ifdef AXI_RD_AR_PIPE_EN
  logic          hold_vld, hold_vld_nxt, from_hold, capture;
  logic [IW-1:0] hold_id;
  logic [AW-1:0] hold_addr;
  logic [LW-1:0] hold_len;
  logic [2:0]    hold_size;
  logic [1:0]    hold_burst;

  // Choose between a direct AR load, a held-request load, or parking the AR
  always_comb begin
    from_hold    = last_hs && hold_vld;
    load         = from_hold || (ar_hs && ((state == ST_IDLE) || (last_hs && !hold_vld)));
    capture      = ar_hs && (state == ST_BURST) && !last_hs;
    hold_vld_nxt = capture ? 1'b1 : (from_hold ? 1'b0 : hold_vld);
    src_id       = from_hold ? hold_id    : S_AXI_ARID;
    src_addr     = from_hold ? hold_addr  : S_AXI_ARADDR;
    src_len      = from_hold ? hold_len   : S_AXI_ARLEN;
    src_size     = from_hold ? hold_size  : S_AXI_ARSIZE;
    src_burst    = from_hold ? hold_burst : S_AXI_ARBURST;
    state_nxt    = state;
    if (load)         state_nxt = ST_BURST;
    else if (last_hs) state_nxt = ST_IDLE;
    arready_nxt  = (state_nxt == ST_IDLE) || !hold_vld_nxt;
  end

  // One-entry holding register for an AR accepted during a burst
  always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
    if (!S_AXI_ARESETN) begin
      hold_vld   <= 1'b0;
      hold_id    <= '0;
      hold_addr  <= '0;
      hold_len   <= '0;
      hold_size  <= '0;
      hold_burst <= '0;
    end else begin
      hold_vld <= hold_vld_nxt;
      if (capture) begin
        hold_id    <= S_AXI_ARID;
        hold_addr  <= S_AXI_ARADDR;
        hold_len   <= S_AXI_ARLEN;
        hold_size  <= S_AXI_ARSIZE;
        hold_burst <= S_AXI_ARBURST;
      end
    end
  end
`else
  // Accept only in IDLE; return to IDLE after the last beat
  always_comb begin
    load      = ar_hs;
    src_id    = S_AXI_ARID;
    src_addr  = S_AXI_ARADDR;
    src_len   = S_AXI_ARLEN;
    src_size  = S_AXI_ARSIZE;
    src_burst = S_AXI_ARBURST;
    state_nxt = state;
    if (load)         state_nxt = ST_BURST;
    else if (last_hs) state_nxt = ST_IDLE;
    arready_nxt = (state_nxt == ST_IDLE);
  end
`endif

  // Control state and latched burst context
  always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
    if (!S_AXI_ARESETN) begin
      state   <= ST_IDLE;
      arready <= 1'b0;
      id_q    <= '0;
      addr_q  <= '0;
      len_q   <= '0;
      cnt_q   <= '0;
      size_q  <= '0;
      burst_q <= '0;
    end else begin
      state   <= state_nxt;
      arready <= arready_nxt;
      if (load) begin
        id_q    <= src_id;
        addr_q  <= src_addr;
        len_q   <= src_len;
        size_q  <= src_size;
        burst_q <= src_burst;
        cnt_q   <= '0;
      end else if (r_hs && !last) begin
        cnt_q  <= cnt_q + LW'(1);
        addr_q <= next_addr;
      end
    end
  end

  assign S_AXI_ARREADY = arready;
  assign S_AXI_RVALID  = (state == ST_BURST);
  assign S_AXI_RID     = id_q;
  assign S_AXI_RDATA   = rdata_c;
  assign S_AXI_RRESP   = (S_AXI_RVALID && slverr) ? 2'b10 : 2'b00;
  assign S_AXI_RLAST   = S_AXI_RVALID && last;

endmodule
